// File: rtl/usb_pkg.sv
// Shared USB definitions: standard request codes, setup packet layout,
// pending-request tag and the EP0 control decoder state encoding.
package usb_pkg;

  localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;
  localparam logic [7:0] RT_STD_DEV_OUT        = 8'h00;

  localparam int SETUP_LEN = 8;

  // Fields in wire order; multi-byte fields are little-endian on the bus.
  typedef struct packed {
    logic [7:0]  bm_request_type;
    logic [7:0]  b_request;
    logic [15:0] w_value;
    logic [15:0] w_index;
    logic [15:0] w_length;
  } setup_pkt_t;

  typedef enum logic [1:0] {NONE, ADDR, CFG} pend_t;

  typedef enum logic [2:0] {IDLE, RECV, DECODE, WAIT_STATUS, COMMIT} state_t;

  // Join two wire bytes into a 16-bit little-endian field.
  function automatic logic [15:0] le16(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/usb_setup_capture.sv
// Collects the 8-byte DATA0 payload of a SETUP transaction, tracks length
// and oversize, and reports whether the packet closed cleanly.
module usb_setup_capture
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       data_valid,
  input  logic [7:0] data_byte,
  input  logic       data_end,
  input  logic       data_err,
  output setup_pkt_t pkt,
  output logic       pkt_ok,
  output logic       pkt_bad
);

  localparam logic [3:0] FULL = 4'(SETUP_LEN);

  logic [3:0]                cnt;
  logic                      oversize;
  logic [SETUP_LEN-1:0][7:0] bytes;

  // Byte store and counter; a byte beyond the eighth only flags oversize.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      oversize <= 1'b0;
      bytes    <= '0;
    end else if (clr) begin
      cnt      <= '0;
      oversize <= 1'b0;
    end else if (en && data_valid) begin
      if (cnt == FULL) oversize <= 1'b1;
      else begin
        bytes[cnt[2:0]] <= data_byte;
        cnt             <= cnt + 4'd1;
      end
    end
  end

  // Assemble the struct and classify the packet end.
  always_comb begin
    pkt.bm_request_type = bytes[0];
    pkt.b_request       = bytes[1];
    pkt.w_value         = le16(bytes[2], bytes[3]);
    pkt.w_index         = le16(bytes[4], bytes[5]);
    pkt.w_length        = le16(bytes[6], bytes[7]);
    // An error in the same cycle as the end marker wins.
    pkt_ok  = en && data_end && !data_err && (cnt == FULL) && !oversize;
    pkt_bad = en && (data_err || (data_end && !pkt_ok));
  end

endmodule

// File: rtl/usb_ctrl_req_decoder.sv
// EP0 control-request decoder: handles SET_ADDRESS / SET_CONFIGURATION,
// commits them after the status stage, hands everything else off.
module usb_ctrl_req_decoder
  import usb_pkg::*;
#(
  parameter logic [7:0]  CNFG_VALUE     = 8'd1,
  parameter logic [15:0] STATUS_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       setup_start,
  input  logic       data_valid,
  input  logic [7:0] data_byte,
  input  logic       data_end,
  input  logic       data_err,
  input  logic       status_ack,
  output logic       setup_ack,
  output logic       req_other,
  output logic       req_stall,
  output logic       addr_set,
  output logic       cnfg_set,
  output logic [6:0] dev_addr,
  output logic [7:0] cnfg_val
);

  state_t     state, state_nx;
  setup_pkt_t pkt;
  logic       pkt_ok, pkt_bad;
  pend_t      pend;
  logic [7:0] pend_val;
  logic [15:0] timer;

  logic is_set_addr, is_set_cfg, addr_ok, cfg_ok, timeout;
  logic load_addr, load_cfg, stall_set, commit, drop;

  usb_setup_capture u_cap (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (setup_start),
    .en        (state == RECV),
    .data_valid(data_valid),
    .data_byte (data_byte),
    .data_end  (data_end),
    .data_err  (data_err),
    .pkt       (pkt),
    .pkt_ok    (pkt_ok),
    .pkt_bad   (pkt_bad)
  );

  // Request classification from the captured packet.
  always_comb begin
    is_set_addr = (pkt.bm_request_type == RT_STD_DEV_OUT) && (pkt.b_request == REQ_SET_ADDRESS);
    is_set_cfg  = (pkt.bm_request_type == RT_STD_DEV_OUT) && (pkt.b_request == REQ_SET_CONFIGURATION);
    addr_ok     = (pkt.w_value[15:7] == '0) && (pkt.w_index == '0) && (pkt.w_length == '0);
    cfg_ok      = (pkt.w_value[15:8] == '0) && (pkt.w_index == '0) && (pkt.w_length == '0) &&
                  ((pkt.w_value[7:0] == CNFG_VALUE) || (pkt.w_value[7:0] == 8'd0));
    timeout     = (timer == (STATUS_TIMEOUT - 16'd1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, register strobes and the state-decoded pulses.
  always_comb begin
    state_nx  = state;
    load_addr = 1'b0;
    load_cfg  = 1'b0;
    stall_set = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    // Pulses depend on state only, so they are glitch-free to the consumer.
    setup_ack = (state == DECODE);
    req_other = (state == DECODE) && !is_set_addr && !is_set_cfg;
    addr_set  = (state == COMMIT) && (pend == ADDR) && (pend_val[6:0] != 7'd0);
    cnfg_set  = (state == COMMIT) && (pend == CFG) && (pend_val == CNFG_VALUE);
    if (setup_start) state_nx = RECV;
    else begin
      case (state)
        IDLE: ;
        RECV: begin
          if (pkt_ok)       state_nx = DECODE;
          else if (pkt_bad) state_nx = IDLE;
        end
        DECODE: begin
          state_nx = IDLE;
          if (is_set_addr) begin
            if (addr_ok) begin
              load_addr = 1'b1;
              state_nx  = WAIT_STATUS;
            end else stall_set = 1'b1;
          end else if (is_set_cfg) begin
            if (cfg_ok) begin
              load_cfg = 1'b1;
              state_nx = WAIT_STATUS;
            end else stall_set = 1'b1;
          end
        end
        WAIT_STATUS: begin
          // A late ACK on the final timer cycle still counts.
          if (status_ack) begin
            commit   = 1'b1;
            state_nx = COMMIT;
          end else if (timeout) begin
            drop     = 1'b1;
            state_nx = IDLE;
          end
        end
        COMMIT:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Status-stage timer: runs only while waiting, restarts from 0 on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    timer <= '0;
    else if (state == WAIT_STATUS) timer <= timer + 16'd1;
    else                           timer <= '0;
  end

  // Pending request, stall level and the committed device registers.
  // Registers load on the status_ack edge so the value and the COMMIT pulse
  // appear together one cycle after the ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= NONE;
      pend_val  <= '0;
      req_stall <= 1'b0;
      dev_addr  <= '0;
      cnfg_val  <= '0;
    end else if (setup_start) begin
      pend      <= NONE;
      req_stall <= 1'b0;
    end else begin
      if (stall_set) req_stall <= 1'b1;
      if (load_addr) begin
        pend     <= ADDR;
        pend_val <= {1'b0, pkt.w_value[6:0]};
      end
      if (load_cfg) begin
        pend     <= CFG;
        pend_val <= pkt.w_value[7:0];
      end
      if (commit && pend == ADDR) dev_addr <= pend_val[6:0];
      if (commit && pend == CFG)  cnfg_val <= pend_val;
      if (drop || state == COMMIT) pend <= NONE;
    end
  end

endmodule

// File: tb/tb_usb_ctrl_req_decoder.sv
// Bench for usb_ctrl_req_decoder: directed table, hand sequences for
// abort/timeout/reset, then random requests against a request-level model.
module tb_usb_ctrl_req_decoder;

  localparam logic [7:0]  CNFG = 8'd1;
  localparam logic [15:0] TO   = 16'd40;

  localparam int K_NONE = 0, K_ADDR = 1, K_CFG = 2, K_STALL = 3, K_OTHER = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       setup_start = 0, data_valid = 0, data_end = 0, data_err = 0, status_ack = 0;
  logic [7:0] data_byte = 0;
  logic       setup_ack, req_other, req_stall, addr_set, cnfg_set;
  logic [6:0] dev_addr;
  logic [7:0] cnfg_val;

  int checks = 0, errors = 0;
  int n_addr = 0, n_cnfg = 0;
  bit prev_a = 0, prev_c = 0;

  usb_ctrl_req_decoder #(.CNFG_VALUE(CNFG), .STATUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .setup_start(setup_start), .data_valid(data_valid),
    .data_byte(data_byte), .data_end(data_end), .data_err(data_err),
    .status_ack(status_ack), .setup_ack(setup_ack), .req_other(req_other),
    .req_stall(req_stall), .addr_set(addr_set), .cnfg_set(cnfg_set),
    .dev_addr(dev_addr), .cnfg_val(cnfg_val)
  );

  always #5 clk = ~clk;

  // Count commit pulses and flag any that lasts two cycles.
  always @(negedge clk) begin
    if (addr_set) n_addr++;
    if (cnfg_set) n_cnfg++;
    if (addr_set || cnfg_set) begin
      checks++;
      if ((addr_set && prev_a) || (cnfg_set && prev_c)) begin
        errors++;
        $display("FAIL pulse_width: addr_set %0b cnfg_set %0b high for 2 cycles", addr_set, cnfg_set);
      end
    end
    prev_a = addr_set;
    prev_c = cnfg_set;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] pkt;
    int          n;
    bit          err;
    bit          ack, other, stall, ap, cp;
    logic [6:0]  addr;
    logic [7:0]  cfg;
  } vec_t;

  vec_t vt[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  // Request-level reference: what the control pipe must do with this packet.
  function automatic void model(input logic [63:0] p, input int n, input bit err,
                                output int kind, output logic [7:0] val);
    int rt, rq, wv, wi, wl;
    rt = int'(p[7:0]);  rq = int'(p[15:8]);
    wv = int'(p[31:16]); wi = int'(p[47:32]); wl = int'(p[63:48]);
    val = p[23:16];
    if (err || n != 8)           kind = K_NONE;
    else if (rt == 0 && rq == 5) kind = (wv < 128 && wi == 0 && wl == 0) ? K_ADDR : K_STALL;
    else if (rt == 0 && rq == 9) kind = ((wv == int'(CNFG) || wv == 0) && wi == 0 && wl == 0) ? K_CFG : K_STALL;
    else                         kind = K_OTHER;
  endfunction

  // SETUP token, n payload bytes, end (or error); returns DECODE-cycle
  // pulses and the stall level one cycle later.
  task automatic send_pkt(input logic [63:0] p, input int n, input bit err,
                          output bit g_ack, output bit g_other, output bit g_stall);
    setup_start = 1; step(); setup_start = 0;
    chk("stall_clear_on_setup", req_stall, 0);
    for (int i = 0; i < n; i++) begin
      data_valid = 1;
      data_byte  = (i < 8) ? p[8*i +: 8] : 8'hA5;
      step();
    end
    data_valid = 0;
    data_end = 1; data_err = err; step(); data_end = 0; data_err = 0;
    g_ack = setup_ack; g_other = req_other;
    step();
    g_stall = req_stall;
  endtask

  // One-cycle status ACK; returns the pulses seen in the following cycle.
  task automatic send_status(output bit g_a, output bit g_c);
    status_ack = 1; step(); status_ack = 0;
    g_a = addr_set; g_c = cnfg_set;
    step();
  endtask

  initial begin
    bit a, o, s, pa, pc;
    int kind;
    logic [7:0] val, b[8];
    logic [6:0] exp_addr;
    logic [7:0] exp_cfg;
    int n, dly, ea, ec;
    bit err, do_st;
    logic [63:0] p;

    vt[0]  = '{mk(8'h00,8'h05,8'h2A,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,0, 1,0, 7'h2A, 8'h00};
    vt[1]  = '{mk(8'h00,8'h09,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,0, 0,1, 7'h2A, 8'h01};
    vt[2]  = '{mk(8'h00,8'h09,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,0, 0,0, 7'h2A, 8'h00};
    vt[3]  = '{mk(8'h00,8'h05,8'h80,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,1, 0,0, 7'h2A, 8'h00};
    vt[4]  = '{mk(8'h00,8'h09,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,1, 0,0, 7'h2A, 8'h00};
    vt[5]  = '{mk(8'h80,8'h06,8'h00,8'h01,8'h00,8'h00,8'h12,8'h00), 8, 0, 1,1,0, 0,0, 7'h2A, 8'h00};
    vt[6]  = '{mk(8'h00,8'h09,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,0, 0,1, 7'h2A, 8'h01};
    vt[7]  = '{mk(8'h00,8'h05,8'h33,8'h00,8'h00,8'h00,8'h00,8'h00), 7, 0, 0,0,0, 0,0, 7'h2A, 8'h01};
    vt[8]  = '{mk(8'h00,8'h05,8'h33,8'h00,8'h00,8'h00,8'h00,8'h00), 9, 0, 0,0,0, 0,0, 7'h2A, 8'h01};
    vt[9]  = '{mk(8'h00,8'h05,8'h33,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 1, 0,0,0, 0,0, 7'h2A, 8'h01};
    vt[10] = '{mk(8'h00,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,0, 0,0, 7'h00, 8'h01};
    vt[11] = '{mk(8'h00,8'h05,8'h7F,8'h00,8'h01,8'h00,8'h00,8'h00), 8, 0, 1,0,1, 0,0, 7'h00, 8'h01};
    vt[12] = '{mk(8'h00,8'h05,8'h7F,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,0,0, 1,0, 7'h7F, 8'h01};
    vt[13] = '{mk(8'h00,8'h09,8'h01,8'h00,8'h00,8'h00,8'h01,8'h00), 8, 0, 1,0,1, 0,0, 7'h7F, 8'h01};
    vt[14] = '{mk(8'h80,8'h05,8'h10,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, 1,1,0, 0,0, 7'h7F, 8'h01};

    // Reset state
    repeat (3) step();
    chk("rst_setup_ack", setup_ack, 0);
    chk("rst_req_other", req_other, 0);
    chk("rst_req_stall", req_stall, 0);
    chk("rst_addr_set",  addr_set, 0);
    chk("rst_cnfg_set",  cnfg_set, 0);
    chk("rst_dev_addr",  dev_addr, 0);
    chk("rst_cnfg_val",  cnfg_val, 0);
    rst_n = 1; step();

    // Directed table
    for (int i = 0; i < 15; i++) begin
      n_addr = 0; n_cnfg = 0;
      send_pkt(vt[i].pkt, vt[i].n, vt[i].err, a, o, s);
      chk($sformatf("v%0d_setup_ack", i), a, vt[i].ack);
      chk($sformatf("v%0d_req_other", i), o, vt[i].other);
      chk($sformatf("v%0d_req_stall", i), s, vt[i].stall);
      send_status(pa, pc);
      chk($sformatf("v%0d_addr_set_lat", i), pa, vt[i].ap);
      chk($sformatf("v%0d_cnfg_set_lat", i), pc, vt[i].cp);
      step();
      chk($sformatf("v%0d_addr_pulses", i), n_addr, vt[i].ap);
      chk($sformatf("v%0d_cnfg_pulses", i), n_cnfg, vt[i].cp);
      chk($sformatf("v%0d_dev_addr", i), dev_addr, vt[i].addr);
      chk($sformatf("v%0d_cnfg_val", i), cnfg_val, vt[i].cfg);
    end

    // New setup before status ACK drops the pending address
    n_addr = 0;
    send_pkt(mk(8'h00,8'h05,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, a, o, s);
    chk("abort_ack", a, 1);
    setup_start = 1; step(); setup_start = 0;
    status_ack = 1; step(); status_ack = 0;
    step(); step();
    chk("abort_pulses", n_addr, 0);
    chk("abort_dev_addr", dev_addr, 7'h7F);

    // setup_start and status_ack in the same cycle: setup wins
    send_pkt(mk(8'h00,8'h05,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, a, o, s);
    setup_start = 1; status_ack = 1; step(); setup_start = 0; status_ack = 0;
    step(); step();
    chk("simul_pulses", n_addr, 0);
    chk("simul_dev_addr", dev_addr, 7'h7F);

    // ACK just inside the timeout window still commits
    n_addr = 0;
    send_pkt(mk(8'h00,8'h05,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, a, o, s);
    repeat (int'(TO) - 2) step();
    send_status(pa, pc);
    chk("late_ack_addr_set", pa, 1);
    chk("late_ack_dev_addr", dev_addr, 7'h05);

    // ACK after the timeout expired: nothing commits
    n_addr = 0;
    send_pkt(mk(8'h00,8'h05,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, a, o, s);
    repeat (int'(TO)) step();
    send_status(pa, pc);
    step();
    chk("timeout_pulses", n_addr, 0);
    chk("timeout_dev_addr", dev_addr, 7'h05);

    // Reset mid WAIT_STATUS
    send_pkt(mk(8'h00,8'h05,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 0, a, o, s);
    step();
    rst_n = 0; #2;
    chk("midrst_dev_addr", dev_addr, 0);
    chk("midrst_cnfg_val", cnfg_val, 0);
    chk("midrst_req_stall", req_stall, 0);
    chk("midrst_pulses", {addr_set, cnfg_set, setup_ack, req_other}, 0);
    step(); rst_n = 1; step();

    // Random requests against the model
    exp_addr = 0; exp_cfg = 0;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 8; k++) b[k] = 8'h00;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          b[1] = 8'h05; b[2] = 8'($urandom_range(0, 127));
          case ($urandom_range(0, 5))
            0: b[3] = 8'($urandom_range(1, 255));
            1: b[4] = 8'($urandom_range(1, 255));
            2: b[7] = 8'($urandom_range(1, 255));
            3: b[2][7] = 1'b1;
            default: ;
          endcase
        end
        4, 5, 6: begin
          b[1] = 8'h09;
          case ($urandom_range(0, 3))
            0: b[2] = 8'h00;
            1: b[2] = 8'h01;
            2: b[2] = 8'h02;
            default: b[2] = 8'($urandom);
          endcase
          if ($urandom_range(0, 5) == 0) b[3] = 8'($urandom_range(1, 255));
        end
        7: for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        8: begin b[0] = 8'h80; b[1] = 8'h06; b[3] = 8'h01; b[6] = 8'h12; end
        default: begin b[0] = 8'($urandom_range(1, 255)); b[1] = 8'h05; b[2] = 8'h09; end
      endcase
      p = mk(b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]);
      n = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 9 : 7) : 8;
      err = ($urandom_range(0, 19) == 0);
      do_st = ($urandom_range(0, 4) != 0);
      dly = $urandom_range(0, 3);

      model(p, n, err, kind, val);
      ea = 0; ec = 0;
      if (do_st && kind == K_ADDR) begin
        exp_addr = val[6:0];
        ea = (val[6:0] != 0) ? 1 : 0;
      end
      if (do_st && kind == K_CFG) begin
        exp_cfg = val;
        ec = (val == CNFG) ? 1 : 0;
      end

      n_addr = 0; n_cnfg = 0;
      send_pkt(p, n, err, a, o, s);
      chk($sformatf("r%0d_setup_ack", it), a, (kind != K_NONE));
      chk($sformatf("r%0d_req_other", it), o, (kind == K_OTHER));
      chk($sformatf("r%0d_req_stall", it), s, (kind == K_STALL));
      repeat (dly) step();
      if (do_st) send_status(pa, pc);
      step();
      chk($sformatf("r%0d_addr_pulses", it), n_addr, ea);
      chk($sformatf("r%0d_cnfg_pulses", it), n_cnfg, ec);
      chk($sformatf("r%0d_dev_addr", it), dev_addr, exp_addr);
      chk($sformatf("r%0d_cnfg_val", it), cnfg_val, exp_cfg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
